// File: rtl/fmap_rmw_ctrl.sv
// Read-modify-write front end for dp_bram: 3-stage update pipeline with forwarding plus a clear sweep.
// Optional macro FMAP_RMW_SAT_EN selects saturating instead of wrapping accumulation.
module fmap_rmw_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DELTA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DELTA_WIDTH-1:0] in_delta,
  input  logic                  clear_req,
  output logic                  clear_done,
  output logic                  busy,
  output logic                  sat_event,
  output logic                  en_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  en_b,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_in_b
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  cnt, cnt_nx;
  logic                   armed, armed_nx;

  logic                   c_valid, w_valid, l_valid;
  logic [ADDR_WIDTH-1:0]  c_addr, w_addr, l_addr;
  logic [DELTA_WIDTH-1:0] c_delta;
  logic [DATA_WIDTH-1:0]  w_sum, l_sum;
  logic                   w_sat;

  logic                   accept;
  logic [DATA_WIDTH-1:0]  operand, sext_delta, result;
  logic                   c_sat;

  assign accept = in_valid && in_ready;

  // C-stage operand: the freshest copy wins, the BRAM read is only used when no write is pending
  always_comb begin
    operand = data_out_a;
    if (w_valid && (w_addr == c_addr))
      operand = w_sum;
    else if (l_valid && (l_addr == c_addr))
      operand = l_sum;
    sext_delta = {{(DATA_WIDTH-DELTA_WIDTH){c_delta[DELTA_WIDTH-1]}}, c_delta};
  end

`ifdef FMAP_RMW_SAT_EN
  logic [DATA_WIDTH:0] sum_ext;
  always_comb begin
    sum_ext = {operand[DATA_WIDTH-1], operand} + {sext_delta[DATA_WIDTH-1], sext_delta};
    c_sat   = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
    result  = sum_ext[DATA_WIDTH-1:0];
    if (c_sat)
      result = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    c_sat  = 1'b0;
    result = operand + sext_delta;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      armed   <= 1'b1;
      c_valid <= 1'b0;
      w_valid <= 1'b0;
      l_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      armed   <= armed_nx;
      c_valid <= accept;
      w_valid <= c_valid;
      l_valid <= w_valid;
    end
    c_addr  <= in_addr;
    c_delta <= in_delta;
    w_addr  <= c_addr;
    w_sum   <= result;
    w_sat   <= c_sat;
    l_addr  <= w_addr;
    l_sum   <= w_sum;
  end

  // armed blocks a second sweep until clear_req has been seen low after clear_done
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    armed_nx = armed | ~clear_req;
    case (state)
      RUN:   if (clear_req && armed) state_nx = DRAIN;
      DRAIN: if (!c_valid && !w_valid && !l_valid) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
             end
      CLEAR: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == {ADDR_WIDTH{1'b1}}) begin
                 state_nx = RUN;
                 armed_nx = 1'b0;
               end
             end
      default: state_nx = RUN;
    endcase
  end

  // Everything is forced to its idle value while rst is high so in-flight writes are dropped
  always_comb begin
    in_ready   = 1'b1;
    en_a       = 1'b0;
    we_a       = 1'b0;
    addr_a     = '0;
    en_b       = 1'b0;
    we_b       = 1'b0;
    addr_b     = '0;
    data_in_b  = '0;
    clear_done = 1'b0;
    busy       = 1'b0;
    sat_event  = 1'b0;
    if (!rst) begin
      in_ready = (state == RUN) && !clear_req;
      if (accept && !(w_valid && (w_addr == in_addr))) begin
        en_a   = 1'b1;
        addr_a = in_addr;
      end
      if (state == CLEAR) begin
        en_b       = 1'b1;
        we_b       = 1'b1;
        addr_b     = cnt;
        clear_done = (cnt == {ADDR_WIDTH{1'b1}});
      end else if (w_valid) begin
        en_b      = 1'b1;
        we_b      = 1'b1;
        addr_b    = w_addr;
        data_in_b = w_sum;
        sat_event = w_sat;
      end
      busy = c_valid || w_valid || l_valid || (state != RUN);
    end
  end

endmodule
